// File: rtl/inqueue_pkg.sv
// Shared definitions for the multi-channel tuple inqueue.
//   ch_w()       : channel-id width, at least 1 bit so NUM_CH=1 still carries an id
//   DROP_CNT_W   : width of each per-channel saturating drop counter
//   inq_entry_t  : buffered entry {fivetuple, pkt_len} at the default widths
package inqueue_pkg;

  localparam int LEN_WIDTH_DEF   = 16;
  localparam int PKT_TUPLE_W_DEF = 104;
  localparam int DROP_CNT_W      = 32;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic [PKT_TUPLE_W_DEF-1:0] fivetuple;
    logic [LEN_WIDTH_DEF-1:0]   pkt_len;
  } inq_entry_t;

endpackage

// File: rtl/inq_chan_fifo.sv
// Per-channel first-word-fall-through FIFO with registered pointers.
//   clk, resetn          : clock, async active-low reset
//   wr_en / wr_data      : push request; ignored while full (judged pre-edge)
//   rd_en                : pop request; ignored while empty (judged pre-edge)
//   rd_data              : current head, valid whenever ~empty
//   empty/full/nearly_full/count : occupancy status
module inq_chan_fifo #(
  parameter int W          = 120,
  parameter int DEPTH_BITS = 4,
  parameter int MARGIN     = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  wr_en,
  input  logic [W-1:0]          wr_data,
  input  logic                  rd_en,
  output logic [W-1:0]          rd_data,
  output logic                  empty,
  output logic                  full,
  output logic                  nearly_full,
  output logic [DEPTH_BITS:0]   count
);

  localparam int DEPTH = 2**DEPTH_BITS;
  localparam logic [DEPTH_BITS:0] CNT_FULL = (DEPTH_BITS+1)'(DEPTH);
  localparam logic [DEPTH_BITS:0] NF_THR   = (DEPTH_BITS+1)'(DEPTH - MARGIN);
  localparam logic [DEPTH_BITS:0] CNT_ONE  = (DEPTH_BITS+1)'(1);
  localparam logic [DEPTH_BITS-1:0] PTR_ONE = DEPTH_BITS'(1);

  logic [W-1:0]            mem [DEPTH];
  logic [DEPTH_BITS-1:0]   wr_ptr, rd_ptr;
  logic                    do_wr, do_rd;

  // Both decisions use the pre-edge count, so a pop on a full FIFO does not
  // open a slot for a same-cycle push, and a push on an empty FIFO is not
  // visible to a same-cycle pop.
  assign do_wr = wr_en & ~full;
  assign do_rd = rd_en & ~empty;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_wr, do_rd})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  assign rd_data     = mem[rd_ptr];
  assign empty       = (count == '0);
  assign full        = (count == CNT_FULL);
  assign nearly_full = (count >= NF_THR);

endmodule

// File: rtl/multi_inqueue.sv
// Multi-channel tuple inqueue: NUM_CH {transtuple, fivetuple} streams are each
// buffered as {fivetuple, pkt_len} and merged round-robin into one registered
// output stream tagged with the channel id.
//   in_transtuple_DATA / in_fivetuple_DATA / in_VALID / in_READY : per-channel inputs
//   out_DATA {chan_id, fivetuple, pkt_len} / out_VALID / out_READY : merged output
//   fifo_empty : per-channel FIFO empty flags
//   drop_cnt   : per-channel saturating drop counters (drop-on-full mode only)
module multi_inqueue
  import inqueue_pkg::*;
#(
  parameter int NUM_CH             = 4,
  parameter int ACTION_TUPLE_WIDTH = 128,
  parameter int PKT_TUPLE_WIDTH    = 104,
  parameter int LEN_WIDTH          = LEN_WIDTH_DEF,
  parameter int DEPTH_BITS         = 4,
  parameter int NEARLY_FULL_MARGIN = 2,
  parameter int DROP_ON_FULL       = 0,
  localparam int CH_W              = ch_w(NUM_CH),
  localparam int EW                = PKT_TUPLE_WIDTH + LEN_WIDTH
) (
  input  logic                               clk,
  input  logic                               resetn,
  input  logic [NUM_CH*ACTION_TUPLE_WIDTH-1:0] in_transtuple_DATA,
  input  logic [NUM_CH*PKT_TUPLE_WIDTH-1:0]  in_fivetuple_DATA,
  input  logic [NUM_CH-1:0]                  in_VALID,
  output logic [NUM_CH-1:0]                  in_READY,
  output logic [CH_W+EW-1:0]                 out_DATA,
  output logic                               out_VALID,
  input  logic                               out_READY,
  output logic [NUM_CH-1:0]                  fifo_empty,
  output logic [NUM_CH*DROP_CNT_W-1:0]       drop_cnt
);

  logic [NUM_CH-1:0][EW-1:0]       head;
  logic [NUM_CH-1:0][DEPTH_BITS:0] cnt;
  logic [NUM_CH-1:0]               empty, full, nfull, wr, pop, drop_ev;
  logic [CH_W-1:0]                 rr_ptr, gnt_id;
  logic                            gnt_vld, load;

  // Only the low LEN_WIDTH bits of each transtuple are buffered; occupancy
  // counts are exported by the FIFO but only the derived flags are needed here.
  logic unused_ok;
  assign unused_ok = ^{in_transtuple_DATA, cnt, nfull};

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [EW-1:0]         entry;
    logic [DROP_CNT_W-1:0] dcnt;

    assign entry = {in_fivetuple_DATA[c*PKT_TUPLE_WIDTH +: PKT_TUPLE_WIDTH],
                    in_transtuple_DATA[c*ACTION_TUPLE_WIDTH +: LEN_WIDTH]};

    if (DROP_ON_FULL != 0) begin : g_drop
      assign in_READY[c] = 1'b1;
    end else begin : g_bp
      // Held low while in reset so upstream never sees a ready it cannot use.
      assign in_READY[c] = resetn & ~nfull[c];
    end

    assign wr[c]      = in_VALID[c] & in_READY[c];
    assign drop_ev[c] = (DROP_ON_FULL != 0) & in_VALID[c] & full[c];

    inq_chan_fifo #(
      .W          (EW),
      .DEPTH_BITS (DEPTH_BITS),
      .MARGIN     (NEARLY_FULL_MARGIN)
    ) u_fifo (
      .clk         (clk),
      .resetn      (resetn),
      .wr_en       (wr[c]),
      .wr_data     (entry),
      .rd_en       (pop[c]),
      .rd_data     (head[c]),
      .empty       (empty[c]),
      .full        (full[c]),
      .nearly_full (nfull[c]),
      .count       (cnt[c])
    );

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)                     dcnt <= '0;
      else if (drop_ev[c] && dcnt != '1) dcnt <= dcnt + DROP_CNT_W'(1);
    end

    assign drop_cnt[c*DROP_CNT_W +: DROP_CNT_W] = dcnt;
  end

  // Round-robin search: first non-empty channel at or after rr_ptr.
  always_comb begin
    int sum;
    logic [CH_W-1:0] idx;
    gnt_vld = 1'b0;
    gnt_id  = '0;
    sum     = 0;
    idx     = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      sum = int'(rr_ptr) + k;
      if (sum >= NUM_CH) sum = sum - NUM_CH;
      idx = CH_W'(sum);
      if (!gnt_vld && !empty[idx]) begin
        gnt_vld = 1'b1;
        gnt_id  = idx;
      end
    end
  end

  assign load = (~out_VALID | out_READY) & gnt_vld;
  assign pop  = load ? (NUM_CH'(1) << gnt_id) : '0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_VALID <= 1'b0;
      out_DATA  <= '0;
      rr_ptr    <= '0;
    end else if (load) begin
      out_VALID <= 1'b1;
      out_DATA  <= {gnt_id, head[gnt_id]};
      rr_ptr    <= (gnt_id == CH_W'(NUM_CH-1)) ? '0 : gnt_id + CH_W'(1);
    end else if (out_READY) begin
      out_VALID <= 1'b0;
    end
  end

  assign fifo_empty = empty;

endmodule

// File: tb/tb_multi_inqueue.sv
// Directed bench for multi_inqueue: one backpressure-mode instance and one
// drop-on-full instance share the input data buses and reset.
module tb_multi_inqueue;
  import inqueue_pkg::*;

  localparam int NC  = 4;
  localparam int ATW = 128;
  localparam int PTW = 104;
  localparam int LW  = 16;
  localparam int OW  = 2 + PTW + LW;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  always #5 clk = ~clk;

  logic [NC*ATW-1:0] tt = '0;
  logic [NC*PTW-1:0] ft = '0;
  logic [NC-1:0]     bp_valid = '0, dp_valid = '0;
  logic [NC-1:0]     bp_ready, dp_ready, bp_empty, dp_empty;
  logic [OW-1:0]     bp_data, dp_data;
  logic              bp_ov, dp_ov;
  logic              bp_or = 1'b0, dp_or = 1'b0;
  logic [NC*32-1:0]  bp_drop, dp_drop;

  int checks = 0;
  int errors = 0;

  multi_inqueue #(.NUM_CH(NC), .DROP_ON_FULL(0)) u_bp (
    .clk(clk), .resetn(resetn),
    .in_transtuple_DATA(tt), .in_fivetuple_DATA(ft),
    .in_VALID(bp_valid), .in_READY(bp_ready),
    .out_DATA(bp_data), .out_VALID(bp_ov), .out_READY(bp_or),
    .fifo_empty(bp_empty), .drop_cnt(bp_drop));

  multi_inqueue #(.NUM_CH(NC), .DROP_ON_FULL(1)) u_dp (
    .clk(clk), .resetn(resetn),
    .in_transtuple_DATA(tt), .in_fivetuple_DATA(ft),
    .in_VALID(dp_valid), .in_READY(dp_ready),
    .out_DATA(dp_data), .out_VALID(dp_ov), .out_READY(dp_or),
    .fifo_empty(dp_empty), .drop_cnt(dp_drop));

  // Upper transtuple bits are set to ones; only the low LW bits may reach the output.
  task automatic put(input int c, input logic [PTW-1:0] f, input logic [LW-1:0] l);
    tt[c*ATW +: ATW] = {{(ATW-LW){1'b1}}, l};
    ft[c*PTW +: PTW] = f;
  endtask

  task automatic put_tag(input int c, input int tag);
    put(c, PTW'(tag), LW'(tag + 256));
  endtask

  function automatic logic [OW-1:0] ent(input int c, input int tag);
    inq_entry_t e;
    e.fivetuple = PTW'(tag);
    e.pkt_len   = LW'(tag + 256);
    return {2'(c), e};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0; bp_valid = '0; dp_valid = '0; bp_or = 1'b0; dp_or = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    #2 resetn = 1'b0;
    #2;
    checks++; if (bp_empty !== 4'hF) begin errors++; $display("FAIL rst_empty got %h exp f", bp_empty); end
    checks++; if (bp_ov !== 1'b0) begin errors++; $display("FAIL rst_ovalid got %b exp 0", bp_ov); end
    checks++; if (bp_data !== '0) begin errors++; $display("FAIL rst_odata got %h exp 0", bp_data); end
    checks++; if (bp_ready !== 4'h0) begin errors++; $display("FAIL rst_ready_bp got %h exp 0", bp_ready); end
    checks++; if (dp_ready !== 4'hF) begin errors++; $display("FAIL rst_ready_dp got %h exp f", dp_ready); end
    checks++; if (dp_drop !== '0) begin errors++; $display("FAIL rst_drop got %h exp 0", dp_drop); end
    @(negedge clk); resetn = 1'b1;
    @(negedge clk);
    checks++; if (bp_ready !== 4'hF) begin errors++; $display("FAIL rel_ready_bp got %h exp f", bp_ready); end
  endtask

  task automatic test_single();
    do_reset();
    bp_or = 1'b1;
    @(posedge clk); #1 put(2, 104'hA5, 16'h0040); bp_valid = 4'b0100;
    @(posedge clk); #1 bp_valid = '0;            // accepted on this edge
    @(negedge clk);
    checks++; if (bp_ov !== 1'b0) begin errors++; $display("FAIL single_t1_ovalid got %b exp 0", bp_ov); end
    checks++; if (bp_empty !== 4'b1011) begin errors++; $display("FAIL single_t1_empty got %b exp 1011", bp_empty); end
    @(negedge clk);
    checks++; if ({bp_ov, bp_data} !== {1'b1, 2'd2, 104'hA5, 16'h0040})
      begin errors++; $display("FAIL single_out got %b/%h exp 1/%h", bp_ov, bp_data, {2'd2, 104'hA5, 16'h0040}); end
    checks++; if (bp_empty !== 4'hF) begin errors++; $display("FAIL single_empty_after got %b exp 1111", bp_empty); end
    @(negedge clk);
    checks++; if (bp_ov !== 1'b0) begin errors++; $display("FAIL single_drained got %b exp 0", bp_ov); end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      for (int c = 0; c < NC; c++) put_tag(c, c*16 + k);
      bp_valid = 4'hF;
    end
    @(posedge clk); #1 bp_valid = '0;
    @(posedge clk); #1 bp_or = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++;
      if ({bp_ov, bp_data} !== {1'b1, ent(i%4, (i%4)*16 + i/4)})
        begin errors++; $display("FAIL rr_seq%0d got %b/%h exp 1/%h", i, bp_ov, bp_data, ent(i%4, (i%4)*16 + i/4)); end
    end
    @(negedge clk);
    checks++; if ({bp_ov, bp_empty} !== 5'b0_1111) begin errors++; $display("FAIL rr_done got %b/%b exp 0/1111", bp_ov, bp_empty); end
  endtask

  task automatic test_backpressure();
    int  acc;
    bit  go, stable;
    do_reset();
    // Park one ch1 entry in the output register so ch0 fills its FIFO alone.
    @(posedge clk); #1 put_tag(1, 'h300); bp_valid = 4'b0010;
    @(posedge clk); #1 bp_valid = '0;
    @(posedge clk); #1 acc = 0; stable = 1'b1; put_tag(0, 'h400); bp_valid = 4'b0001;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      go = bp_ready[0];
      if ({bp_ov, bp_data} !== {1'b1, ent(1, 'h300)}) stable = 1'b0;
      @(posedge clk); #1;
      if (go) begin acc++; put_tag(0, 'h400 + acc); end
    end
    bp_valid = '0;
    checks++; if (acc != 14) begin errors++; $display("FAIL bp_accepts got %0d exp 14", acc); end
    checks++; if (bp_ready[0] !== 1'b0) begin errors++; $display("FAIL bp_ready0 got %b exp 0", bp_ready[0]); end
    checks++; if (!stable) begin errors++; $display("FAIL bp_stall_stable got 0 exp 1"); end
    checks++; if (bp_empty !== 4'b1110) begin errors++; $display("FAIL bp_empty got %b exp 1110", bp_empty); end
    bp_or = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      checks++;
      if ({bp_ov, bp_data} !== {1'b1, (i == 0) ? ent(1, 'h300) : ent(0, 'h400 + i - 1)})
        begin errors++; $display("FAIL bp_drain%0d got %b/%h", i, bp_ov, bp_data); end
    end
    @(negedge clk);
    checks++; if (bp_ov !== 1'b0) begin errors++; $display("FAIL bp_drain_end got %b exp 0", bp_ov); end
  endtask

  task automatic test_drop();
    do_reset();
    @(posedge clk); #1 put_tag(0, 'h500); dp_valid = 4'b0001;
    @(posedge clk); #1 dp_valid = '0;
    @(posedge clk); #1;
    for (int i = 0; i < 21; i++) begin
      put_tag(1, 'h600 + i); dp_valid = 4'b0010;
      @(posedge clk); #1;
    end
    dp_valid = '0;
    @(negedge clk);
    checks++; if (dp_drop !== {32'd0, 32'd0, 32'd5, 32'd0}) begin errors++; $display("FAIL drop_cnt got %h exp ch1=5", dp_drop); end
    checks++; if (dp_ready !== 4'hF) begin errors++; $display("FAIL drop_ready got %b exp 1111", dp_ready); end
    checks++; if (dp_empty !== 4'b1101) begin errors++; $display("FAIL drop_empty got %b exp 1101", dp_empty); end
    @(posedge clk); #1 dp_or = 1'b1;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      checks++;
      if ({dp_ov, dp_data} !== {1'b1, (i == 0) ? ent(0, 'h500) : ent(1, 'h600 + i - 1)})
        begin errors++; $display("FAIL drop_drain%0d got %b/%h", i, dp_ov, dp_data); end
    end
    @(negedge clk);
    checks++; if (dp_ov !== 1'b0) begin errors++; $display("FAIL drop_drain_end got %b exp 0", dp_ov); end
    checks++; if (bp_drop !== '0) begin errors++; $display("FAIL bp_drop_zero got %h exp 0", bp_drop); end
  endtask

  task automatic test_toggle();
    logic [OW-1:0] exp_q [4];
    int n;
    exp_q[0] = ent(0, 'h700); exp_q[1] = ent(3, 'h730);
    exp_q[2] = ent(0, 'h701); exp_q[3] = ent(3, 'h731);
    n = 0;
    do_reset();
    @(posedge clk); #1 put_tag(0, 'h700); put_tag(3, 'h730); bp_valid = 4'b1001;
    @(posedge clk); #1 put_tag(0, 'h701); put_tag(3, 'h731);
    @(posedge clk); #1 bp_valid = '0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      bp_or = (cyc % 2 == 0);
      @(negedge clk);
      if (bp_ov && bp_or) begin
        if (n < 4) begin
          checks++;
          if (bp_data !== exp_q[n]) begin errors++; $display("FAIL tog_xfer%0d got %h exp %h", n, bp_data, exp_q[n]); end
        end
        n++;
      end
      @(posedge clk); #1;
    end
    checks++; if (n != 4) begin errors++; $display("FAIL tog_count got %0d exp 4", n); end
    checks++; if ({bp_ov, bp_empty} !== 5'b0_1111) begin errors++; $display("FAIL tog_done got %b/%b exp 0/1111", bp_ov, bp_empty); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bp_or = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1 put_tag(0, 'h800 + k); put_tag(1, 'h810 + k); bp_valid = 4'b0011;
    end
    @(negedge clk);
    checks++; if (bp_ov !== 1'b1) begin errors++; $display("FAIL mid_busy got %b exp 1", bp_ov); end
    #2 resetn = 1'b0;
    #1;
    checks++; if ({bp_ov, bp_data} !== {1'b0, {OW{1'b0}}}) begin errors++; $display("FAIL mid_out got %b/%h exp 0/0", bp_ov, bp_data); end
    checks++; if (bp_empty !== 4'hF) begin errors++; $display("FAIL mid_empty got %b exp 1111", bp_empty); end
    checks++; if (bp_ready !== 4'h0) begin errors++; $display("FAIL mid_ready got %b exp 0000", bp_ready); end
    bp_valid = '0;
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1 put_tag(3, 'h900); bp_valid = 4'b1000;
    @(posedge clk); #1 bp_valid = '0;
    @(negedge clk);
    checks++; if ({bp_ov, bp_empty} !== 5'b0_0111) begin errors++; $display("FAIL mid_t1 got %b/%b exp 0/0111", bp_ov, bp_empty); end
    @(negedge clk);
    checks++; if ({bp_ov, bp_data} !== {1'b1, ent(3, 'h900)}) begin errors++; $display("FAIL mid_t2 got %b/%h exp 1/%h", bp_ov, bp_data, ent(3, 'h900)); end
    @(negedge clk);
    checks++; if ({bp_ov, bp_empty} !== 5'b0_1111) begin errors++; $display("FAIL mid_leftover got %b/%b exp 0/1111", bp_ov, bp_empty); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_drop();
    test_toggle();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_inqueue.md
Name: multi_inqueue

Overview:
- Multi-channel successor of the single-channel tuple inqueue.
- Accepts NUM_CH independent {transtuple, fivetuple} streams and buffers each in its own FIFO as a {fivetuple, pkt_len} entry.
- Merges the channel FIFOs round-robin into one registered output stream tagged with channel id, for the packet-generator scheduler.
- Adds optional drop-on-full mode with per-channel saturating drop counters.

Parameters:
- NUM_CH, 4, number of input channels (1..16).
- ACTION_TUPLE_WIDTH, 128, transtuple width per channel.
- PKT_TUPLE_WIDTH, 104, fivetuple width per channel.
- LEN_WIDTH, 16, packet length field, taken from transtuple[LEN_WIDTH-1:0].
- DEPTH_BITS, 4, per-channel FIFO depth = 2**DEPTH_BITS.
- NEARLY_FULL_MARGIN, 2, in_ready drops when free entries <= margin.
- DROP_ON_FULL, 0, 0 = backpressure, 1 = always ready and drop when full.
- Localparam CH_W = (NUM_CH>1) ? $clog2(NUM_CH) : 1.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- in_transtuple_DATA  in  NUM_CH*ACTION_TUPLE_WIDTH  channel c at slice [c*ACTION_TUPLE_WIDTH +: ACTION_TUPLE_WIDTH].
- in_fivetuple_DATA  in  NUM_CH*PKT_TUPLE_WIDTH  channel c fivetuple.
- in_VALID  in  NUM_CH  per-channel valid; transtuple and fivetuple are qualified together.
- in_READY  out  NUM_CH  per-channel ready.
- out_DATA  out  CH_W+PKT_TUPLE_WIDTH+LEN_WIDTH  {chan_id, fivetuple, pkt_len}.
- out_VALID  out  1  output entry valid.
- out_READY  in  1  downstream accepts.
- fifo_empty  out  NUM_CH  per-channel FIFO empty flag.
- drop_cnt  out  NUM_CH*32  per-channel saturating drop count; stays 0 when DROP_ON_FULL=0.

Behaviour:
- Reset (asynchronous assert, synchronous release) clears:
  - all FIFO pointers and counts, so fifo_empty = all 1s;
  - out_VALID = 0 and out_DATA = 0;
  - drop_cnt = 0 and the round-robin pointer = 0.
- Reset clears in_READY to 0 in backpressure mode. It reads 1 after reset in drop mode.
- Reset mid-operation discards all buffered entries. No partial output may appear.
- Write, backpressure mode (DROP_ON_FULL=0):
  - in_READY[c] = ~nearly_full[c], where nearly_full means count >= 2**DEPTH_BITS - NEARLY_FULL_MARGIN;
  - write occurs when in_VALID[c] & in_READY[c];
  - entry = {fivetuple, transtuple[LEN_WIDTH-1:0]}, captured on that edge.
- Write, drop mode (DROP_ON_FULL=1):
  - in_READY[c] = 1;
  - in_VALID[c] while the FIFO is truly full discards the beat and increments drop_cnt[c], saturating at 32'hFFFFFFFF;
  - the margin is ignored in this mode.
- Per-channel FIFO is first-word-fall-through with registered pointers. An entry written at edge T is visible in the FIFO head after T. fifo_empty[c] deasserts in cycle T+1.
- Simultaneous write and read on a full FIFO: the read frees a slot but the write is still judged on the pre-edge state. It is refused in backpressure mode and dropped in drop mode.
- Simultaneous write and read on an empty FIFO: the read cannot occur, and the write succeeds.
- Output stage is a single register:
  - loads when (~out_VALID | out_READY) and at least one FIFO is non-empty;
  - the chosen channel's FIFO is popped on the same edge;
  - minimum latency from input accept to out_VALID is 2 cycles (T accept, T+1 FIFO head, T+2 out_VALID).
- Arbitration is round-robin: search starts at rr_ptr. After a grant to channel g, rr_ptr = (g+1) mod NUM_CH, wrapping at NUM_CH-1 to 0.
- If out_VALID & ~out_READY, out_DATA and out_VALID hold stable, and no FIFO is popped.
- Sustained throughput is 1 entry/cycle when out_READY = 1.
- Ordering is preserved within a channel. No ordering is guaranteed across channels beyond the round-robin rule.
- NUM_CH=1 degenerates to a single queue with chan_id = 0.

Decomposition:
- Package inqueue_pkg holds:
  - the clog2-based CH_W helper function;
  - the entry struct/width constants (LEN_WIDTH default 16);
  - the drop counter width (32).
- One natural sub-module, inq_chan_fifo: a parametrised FWFT FIFO with count, nearly_full, full, empty and registered pointers, instantiated NUM_CH times via generate.
- The arbiter and output register stay in the top.

Test Plan:
- NUM_CH=4. Single beat on ch2, len=16'h0040, fivetuple=104'hA5 -> out_VALID at cycle +2 with out_DATA={2'd2, 104'hA5, 16'h0040}; fifo_empty=4'b1111 afterwards.
- All 4 channels hold 3 entries each, out_READY=1 -> output chan_id sequence 0,1,2,3,0,1,2,3,0,1,2,3, one per cycle; ordering inside each channel preserved.
- Backpressure mode, DEPTH_BITS=4, margin 2, out_READY=0 -> in_READY[0] falls after 14 accepted writes; no data lost; out_DATA stable while stalled.
- Drop mode, ch1 FIFO full, 5 further valid beats -> drop_cnt[1]=5, other counters 0; the 16 buffered entries drain intact.
- out_READY toggling 1,0,1,0 with ch0 and ch3 active -> no duplicate or skipped entries; rr_ptr wraps from 3 to 0.
- resetn asserted asynchronously mid-burst -> out_VALID=0 immediately; fifo_empty all 1s; after release, the first new input appears 2 cycles after accept.
